// File: rtl/nf_reg_wb.sv
// Register-file write-back arbiter: ALU writes take priority over a 2-entry load FIFO,
// with a pending-load scoreboard for decode stalls. Optional macro NF_WB_BYPASS_EN.
module nf_reg_wb (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_we,
  input  logic [4:0]  alu_wa,
  input  logic [31:0] alu_wd,
  input  logic        ld_iss_vld,
  input  logic [4:0]  ld_iss_wa,
  input  logic        lsu_vld,
  input  logic [4:0]  lsu_wa,
  input  logic [31:0] lsu_wd,
  output logic        lsu_rdy,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic        stall,
  output logic [4:0]  wa3,
  output logic [31:0] wd3,
  output logic        we3,
  output logic        err_waw
);

  logic [4:0]  fifo_wa_q [2];
  logic [31:0] fifo_wd_q [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] pend_q, pend_d;
  logic        err_q, err_d;

  logic alu_eff, fifo_empty, fifo_full, lsu_keep, bypass, pop, push;

  always_comb begin
    alu_eff    = alu_we && (alu_wa != 5'd0);
    fifo_empty = (cnt_q == 2'd0);
    fifo_full  = (cnt_q == 2'd2);
    lsu_rdy    = !rst && !fifo_full;
    // Data for x0 is accepted but never stored or written.
    lsu_keep   = lsu_vld && lsu_rdy && (lsu_wa != 5'd0);
`ifdef NF_WB_BYPASS_EN
    bypass     = lsu_keep && fifo_empty && !alu_eff;
`else
    bypass     = 1'b0;
`endif
    pop        = !rst && !alu_eff && !fifo_empty;
    push       = lsu_keep && !bypass;
    cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_comb begin
    we3 = 1'b0;
    wa3 = 5'd0;
    wd3 = 32'd0;
    if (!rst) begin
      if (alu_eff) begin
        we3 = 1'b1;
        wa3 = alu_wa;
        wd3 = alu_wd;
      end else if (!fifo_empty) begin
        we3 = 1'b1;
        wa3 = fifo_wa_q[rd_ptr_q];
        wd3 = fifo_wd_q[rd_ptr_q];
      end else if (bypass) begin
        we3 = 1'b1;
        wa3 = lsu_wa;
        wd3 = lsu_wd;
      end
    end
  end

  // Load writes retire the pending bit; a same-cycle re-issue sets it again afterwards.
  always_comb begin
    pend_d = pend_q;
    if (pop || bypass) pend_d[wa3] = 1'b0;
    if (ld_iss_vld && (ld_iss_wa != 5'd0)) pend_d[ld_iss_wa] = 1'b1;
    pend_d[0] = 1'b0;
    err_d = err_q | (alu_eff && pend_q[alu_wa]);
  end

  always_comb begin
    stall   = !rst && (pend_q[ra1] || pend_q[ra2]);
    err_waw = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      pend_q   <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_q ^ pop;
      wr_ptr_q <= wr_ptr_q ^ push;
      pend_q   <= pend_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wa_q[wr_ptr_q] <= lsu_wa;
      fifo_wd_q[wr_ptr_q] <= lsu_wd;
    end
  end

endmodule

// File: doc/nf_reg_wb.md
NF_REG_WB -- requirements
Module: nf_reg_wb

Interface
REQ-001 SHALL have port: clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port: alu_we  input  1  ALU result write request, always accepted.
REQ-004 SHALL have port: alu_wa  input  5  ALU destination register.
REQ-005 SHALL have port: alu_wd  input  32  ALU result data.
REQ-006 SHALL have port: ld_iss_vld  input  1  load issued; mark destination pending.
REQ-007 SHALL have port: ld_iss_wa  input  5  issued load destination register.
REQ-008 SHALL have port: lsu_vld  input  1  load data valid.
REQ-009 SHALL have port: lsu_wa  input  5  load data destination register.
REQ-010 SHALL have port: lsu_wd  input  32  load data.
REQ-011 SHALL have port: lsu_rdy  output  1  load data accepted when lsu_vld and lsu_rdy are both high.
REQ-012 SHALL have port: ra1  input  5  decode read address 1, used for the hazard check.
REQ-013 SHALL have port: ra2  input  5  decode read address 2, used for the hazard check.
REQ-014 SHALL have port: stall  output  1  decode stall on a pending-load read.
REQ-015 SHALL have port: wa3  output  5  register file write address.
REQ-016 SHALL have port: wd3  output  32  register file write data.
REQ-017 SHALL have port: we3  output  1  register file write enable.
REQ-018 SHALL have port: err_waw  output  1  sticky flag: ALU wrote a register with a load pending.

Function
REQ-019 SHALL treat any request with address 0 (alu_wa, ld_iss_wa, lsu_wa) as no write; x0 is never written and never pending, and data for x0 is accepted and dropped.
REQ-020 SHALL buffer accepted load data in a 2-entry in-order FIFO; lsu_rdy = FIFO not full; no push occurs while full.
REQ-021 SHALL arbitrate writes combinationally with ALU priority: an effective alu_we (address nonzero) drives alu_wa/alu_wd and we3=1; otherwise a non-empty FIFO drives its head and pops at the clock edge; otherwise we3=0, wa3=0, wd3=0.
REQ-022 SHALL pop and push the FIFO in the same cycle when it is non-empty and not full; count is unchanged and order is preserved.
REQ-023 SHALL keep a 32-bit pending scoreboard: ld_iss_vld sets bit ld_iss_wa, and a FIFO write to the register file clears bit wa3.
REQ-024 SHALL let set win when set and clear hit the same bit in the same cycle, so a re-issued load stays pending.
REQ-025 SHALL drive stall = pend[ra1] | pend[ra2] combinationally from the registered scoreboard; ra=0 never stalls.
REQ-026 SHALL set err_waw, sticky until reset, when an effective ALU write targets a register whose pending bit is set.
REQ-027 SHALL have latency: ALU write reaches the register file in the same cycle; load data reaches it no earlier than the cycle after acceptance (see REQ-032 for the exception).
REQ-028 SHALL starve FIFO drain while alu_we is continuous; no fairness is required, and lsu_rdy backpressure bounds the loss.

Reset
REQ-029 SHALL, while rst=1 at a rising edge, clear the FIFO (count 0), the scoreboard, and err_waw; rst mid-transfer discards buffered load data.
REQ-030 SHALL force we3=0, lsu_rdy=0, and stall=0 while rst is high; after reset, lsu_rdy=1, stall=0, err_waw=0, and we3=0 until a request arrives.

Configuration
REQ-031 SHALL use macro NF_WB_BYPASS_EN to select load-data bypass.
REQ-032 SHALL, with NF_WB_BYPASS_EN defined, pass accepted lsu data directly to wa3/wd3 with we3=1 in the same cycle, without a push, when the FIFO is empty and there is no effective ALU write; the pending bit clears as for a FIFO write.
REQ-033 SHALL, without NF_WB_BYPASS_EN, always pass accepted load data through the FIFO, giving a minimum load latency of 1 cycle.

Verification
REQ-034 SHALL cover: alu_we=1, alu_wa=5, alu_wd=0xDEADBEEF -> same cycle we3=1, wa3=5, wd3=0xDEADBEEF; alu_wa=0 -> we3=0.
REQ-035 SHALL cover: ld_iss wa=7, then ra1=7 -> stall=1 each cycle; lsu_vld wa=7, wd=0x12 -> we3=1 with wa3=7 next cycle (or same cycle with bypass), then stall=0 the following cycle.
REQ-036 SHALL cover: alu_we held high while 3 lsu words are offered -> 2 accepted, then lsu_rdy=0; alu_we drops -> FIFO drains in 2 cycles in order and lsu_rdy returns to 1.
REQ-037 SHALL cover: ld_iss wa=3 in the same cycle as the FIFO writes wa3=3 -> pend[3] stays 1 and ra2=3 keeps stall=1.
REQ-038 SHALL cover: pending reg 9 plus alu_we wa=9 -> err_waw=1 and it stays 1 until rst; rst with 2 FIFO entries -> no further we3 and lsu_rdy=1 after reset.
